// File: rtl/mem_lsu.sv
// Load/store unit between core and memory bus: byte-strobed sub-word stores, two-beat split of
// boundary-crossing accesses, valid/ready bus handshake and sign/zero-extended load return.
module mem_lsu #(
  parameter int XLEN       = 32,
  parameter int ADDR_W     = 32,
  parameter int MISALIGNED = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_fault,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_wstrb,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);
  localparam int NB  = XLEN / 8;
  localparam int OFS = $clog2(NB);

  typedef enum logic [2:0] {S_IDLE, S_BEAT0, S_RD0, S_BEAT1, S_RD1, S_RESP} state_t;

  function automatic logic [XLEN-1:0] rotl(input logic [XLEN-1:0] d, input logic [OFS-1:0] off);
    int sh;
    sh = 8 * int'(off);
    return (d << sh) | (d >> (XLEN - sh));
  endfunction

  function automatic logic [XLEN-1:0] rotr(input logic [XLEN-1:0] d, input logic [OFS-1:0] off);
    int sh;
    sh = 8 * int'(off);
    return (d >> sh) | (d << (XLEN - sh));
  endfunction

  // Lanes touched across both beats: low half is beat0, high half is beat1.
  function automatic logic [2*NB-1:0] lane_mask(input logic [OFS-1:0] off, input logic [1:0] sz);
    logic [2*NB-1:0] m;
    m = '0;
    for (int i = 0; i < 2*NB; i++)
      if (i >= int'(off) && i < int'(off) + (1 << sz)) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d, input logic [1:0] sz,
                                             input logic sg);
    logic [XLEN-1:0] r;
    logic            fill;
    int              nbits;
    nbits = 8 << sz;
    r     = d;
    fill  = 1'b0;
    if (nbits < XLEN) begin
      fill = sg & d[nbits-1];
      for (int i = 0; i < XLEN; i++)
        if (i >= nbits) r[i] = fill;
    end
    return r;
  endfunction

  state_t            state_q;
  logic              req_ready_q, rsp_valid_q, rsp_fault_q, mem_valid_q, mem_we_q;
  logic [XLEN-1:0]   rsp_rdata_q, mem_wdata_q, rbuf_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [NB-1:0]     mem_wstrb_q, strb1_q;
  logic              we_q, sgn_q, cross_q;
  logic [1:0]        size_q;
  logic [OFS-1:0]    off_q;

  logic [OFS-1:0]    req_off;
  logic [2:0]        amask;
  logic              fault_d, cross_d;
  logic [2*NB-1:0]   mask_req_d;
  logic [XLEN-1:0]   rd_rot_d, keep_d, rd_asm_d, ld_ext_d;

  always_comb begin
    req_off = req_addr[OFS-1:0];
    case (req_size)
      2'd0:    amask = 3'b000;
      2'd1:    amask = 3'b001;
      2'd2:    amask = 3'b011;
      default: amask = 3'b111;
    endcase
    fault_d    = ((req_size == 2'd3) && (XLEN == 32)) ||
                 ((MISALIGNED == 0) && ((req_addr[2:0] & amask) != 3'd0));
    cross_d    = (int'(req_off) + (1 << req_size)) > NB;
    mask_req_d = lane_mask(req_off, req_size);
    // Rotating right by the offset puts both beats' bytes at their address-order positions.
    rd_rot_d   = rotr(mem_rdata, off_q);
    keep_d     = {XLEN{1'b1}} >> (8 * int'(off_q));
    rd_asm_d   = (state_q == S_RD1) ? ((rbuf_q & keep_d) | (rd_rot_d & ~keep_d)) : rd_rot_d;
    ld_ext_d   = extend(rd_asm_d, size_q, sgn_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_rdata_q <= '0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wstrb_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (req_valid) begin
          we_q        <= req_we;
          size_q      <= req_size;
          sgn_q       <= req_signed;
          off_q       <= req_off;
          cross_q     <= cross_d;
          strb1_q     <= mask_req_d[2*NB-1:NB];
          req_ready_q <= 1'b0;
          if (fault_d) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_fault_q <= 1'b1;
            rsp_rdata_q <= '0;
          end else begin
            state_q     <= S_BEAT0;
            mem_valid_q <= 1'b1;
            mem_addr_q  <= {req_addr[ADDR_W-1:OFS], {OFS{1'b0}}};
            mem_we_q    <= req_we;
            mem_wstrb_q <= req_we ? mask_req_d[NB-1:0] : '0;
            mem_wdata_q <= req_we ? rotl(req_wdata, req_off) : '0;
          end
        end
        S_BEAT0: if (mem_ready) begin
          mem_valid_q <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_wstrb_q <= '0;
          if (!we_q) state_q <= S_RD0;
          else if (cross_q) state_q <= S_BEAT1;
          else begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
          end
        end
        S_RD0: if (mem_rvalid) begin
          rbuf_q <= rd_rot_d;
          if (cross_q) state_q <= S_BEAT1;
          else begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= ld_ext_d;
          end
        end
        // First BEAT1 cycle sets up the second beat; the request goes out the cycle after.
        S_BEAT1: if (!mem_valid_q) begin
          mem_valid_q <= 1'b1;
          mem_addr_q  <= mem_addr_q + ADDR_W'(NB);
          mem_we_q    <= we_q;
          mem_wstrb_q <= we_q ? strb1_q : '0;
        end else if (mem_ready) begin
          mem_valid_q <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_wstrb_q <= '0;
          if (we_q) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
          end else state_q <= S_RD1;
        end
        S_RD1: if (mem_rvalid) begin
          state_q     <= S_RESP;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= ld_ext_d;
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          rsp_fault_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_fault = rsp_fault_q;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: byte-array memory model with stalls and read latency, checked against a
// byte-level reference of the access rules.
module tb_mem_lsu;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_fault;
  logic [31:0] rsp_rdata;
  logic        mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  logic        b_req_valid, b_req_ready, b_req_we, b_req_signed;
  logic [1:0]  b_req_size;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_rsp_valid, b_rsp_fault;
  logic [31:0] b_rsp_rdata;
  logic        b_mem_valid, b_mem_we;
  logic [31:0] b_mem_addr, b_mem_wdata;
  logic [3:0]  b_mem_wstrb;

  always #5 clk = ~clk;

  mem_lsu #(.XLEN(32), .ADDR_W(32), .MISALIGNED(1)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  mem_lsu #(.XLEN(32), .ADDR_W(32), .MISALIGNED(0)) u_dut_al (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we), .req_size(b_req_size),
    .req_signed(b_req_signed), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_fault(b_rsp_fault),
    .mem_valid(b_mem_valid), .mem_ready(1'b1), .mem_addr(b_mem_addr), .mem_we(b_mem_we),
    .mem_wstrb(b_mem_wstrb), .mem_wdata(b_mem_wdata), .mem_rvalid(1'b1), .mem_rdata(32'h0)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] data;
  } beat_t;

  int          n_chk = 0, n_err = 0, n_hold = 0;
  logic [7:0]  mem_b [0:63];
  logic [7:0]  ref_b [0:63];
  beat_t       beats_q [$];
  beat_t       hold;
  logic        held = 1'b0, rand_wait = 1'b0, chk_latency = 1'b1;
  int          stall_left = 0, rd_cnt = 0, rd_lag = -1;
  logic [31:0] rd_addr;
  logic [31:0] got_rd;
  int          got_lat;

  task automatic chk_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    int b;
    b = int'(a[5:0]);
    return {mem_b[b+3], mem_b[b+2], mem_b[b+1], mem_b[b]};
  endfunction

  // Bus slave: decides mem_ready on the falling edge for the coming rising edge.
  initial begin
    logic go;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_word(rd_addr);
        end
      end
      if (mem_valid === 1'b1) begin
        if (held) begin
          chk_val("hold addr", mem_addr, hold.addr);
          chk_val("hold we", mem_we, hold.we);
          chk_val("hold wstrb", mem_wstrb, hold.strb);
          chk_val("hold wdata", mem_wdata, hold.data);
          n_hold++;
        end
        if (stall_left > 0) begin
          stall_left--;
          go = 1'b0;
        end else go = rand_wait ? ($urandom_range(0, 2) != 0) : 1'b1;
        mem_ready = go;
        if (go) begin
          held = 1'b0;
          beats_q.push_back('{mem_addr, mem_we, mem_wstrb, mem_wdata});
          if (mem_we) begin
            for (int i = 0; i < 4; i++)
              if (mem_wstrb[i]) mem_b[int'(mem_addr[5:0]) + i] = mem_wdata[8*i +: 8];
          end else begin
            rd_cnt  = 1 + ((rd_lag >= 0) ? rd_lag : (rand_wait ? int'($urandom_range(0, 2)) : 0));
            rd_addr = mem_addr;
          end
        end else begin
          held = 1'b1;
          hold = '{mem_addr, mem_we, mem_wstrb, mem_wdata};
        end
      end else begin
        held      = 1'b0;
        mem_ready = ($urandom_range(0, 1) == 1);
      end
    end
  end

  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd, input int lat_extra);
    int          off, nb, lat, ebeats, elat;
    logic [31:0] erd, base;
    logic        efault;
    off    = int'(addr[1:0]);
    nb     = 1 << sz;
    efault = (sz == 2'd3);
    erd    = '0;
    base   = {addr[31:2], 2'b00};
    ebeats = efault ? 0 : ((off + nb > 4) ? 2 : 1);
    if (efault)  elat = 1;
    else if (we) elat = (ebeats == 2) ? 4 : 2;
    else         elat = (ebeats == 2) ? 6 : 3;
    elat += lat_extra;
    if (!efault) begin
      if (we) begin
        for (int i = 0; i < nb; i++) ref_b[int'(addr[5:0]) + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < nb; i++) erd |= 32'(ref_b[int'(addr[5:0]) + i]) << (8*i);
        if (sg && nb < 4 && erd[8*nb-1]) erd |= 32'hFFFF_FFFF << (8*nb);
      end
    end
    @(negedge clk);
    beats_q.delete();
    chk_val("req_ready idle", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk_val("req_ready busy", req_ready, 0);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    chk_val("rsp timeout", rsp_valid, 1);
    got_rd  = rsp_rdata;
    got_lat = lat;
    chk_val("rsp_fault", rsp_fault, efault);
    chk_val("rsp_rdata", rsp_rdata, erd);
    if (chk_latency) chk_val("latency", lat, elat);
    else             chk_val("latency min", lat >= elat, 1);
    chk_val("beat count", beats_q.size(), ebeats);
    if (beats_q.size() >= 1 && ebeats >= 1) chk_val("beat0 addr", beats_q[0].addr, base);
    if (beats_q.size() == 2 && ebeats == 2) chk_val("beat1 addr", beats_q[1].addr, base + 4);
    foreach (beats_q[k]) begin
      chk_val("beat we", beats_q[k].we, we);
      if (!we) chk_val("read wstrb", beats_q[k].strb, 0);
    end
    @(posedge clk); #1;
    chk_val("rsp pulse", rsp_valid, 0);
    chk_val("req_ready after", req_ready, 1);
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    req_valid = 0; req_we = 0; req_size = 0; req_signed = 0; req_addr = 0; req_wdata = 0;
    b_req_valid = 0; b_req_we = 0; b_req_size = 0; b_req_signed = 0; b_req_addr = 0; b_req_wdata = 0;
    for (int i = 0; i < 64; i++) mem_b[i] = 8'($urandom);
    {mem_b[3], mem_b[2], mem_b[1], mem_b[0]} = 32'h9A33_2211;
    {mem_b[7], mem_b[6], mem_b[5], mem_b[4]} = 32'h8877_6655;
    for (int i = 0; i < 64; i++) ref_b[i] = mem_b[i];

    repeat (3) @(posedge clk);
    #1;
    chk_val("rst req_ready", req_ready, 1);
    chk_val("rst rsp_valid", rsp_valid, 0);
    chk_val("rst rsp_fault", rsp_fault, 0);
    chk_val("rst rsp_rdata", rsp_rdata, 0);
    chk_val("rst mem_valid", mem_valid, 0);
    chk_val("rst mem_we", mem_we, 0);
    chk_val("rst mem_wstrb", mem_wstrb, 0);
    chk_val("rst mem_addr", mem_addr, 0);
    chk_val("rst mem_wdata", mem_wdata, 0);
    @(negedge clk);
    reset = 1'b0;

    do_req(1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 0);
    chk_val("lb signed", got_rd, 32'hFFFF_FF9A);
    do_req(1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 0);
    chk_val("lbu", got_rd, 32'h0000_009A);
    do_req(1'b0, 2'd2, 1'b0, 32'h1002, 32'h0, 0);
    chk_val("lw split", got_rd, 32'h6655_9A33);
    chk_val("lw split latency", got_lat, 6);

    do_req(1'b1, 2'd1, 1'b0, 32'h1003, 32'h0000_BEEF, 0);
    if (beats_q.size() == 2) begin
      chk_val("sh beat0 wstrb", beats_q[0].strb, 4'b1000);
      chk_val("sh beat0 lane3", beats_q[0].data[31:24], 8'hEF);
      chk_val("sh beat1 wstrb", beats_q[1].strb, 4'b0001);
      chk_val("sh beat1 lane0", beats_q[1].data[7:0], 8'hBE);
    end
    chk_val("sh word0", mem_word(32'h1000), 32'hEF33_2211);
    chk_val("sh word1", mem_word(32'h1004), 32'h8877_66BE);

    stall_left = 5;
    n_hold = 0;
    do_req(1'b1, 2'd2, 1'b0, 32'h1004, 32'hDEAD_BEEF, 5);
    chk_val("stall holds", n_hold, 5);
    if (beats_q.size() == 1) begin
      chk_val("sw addr", beats_q[0].addr, 32'h1004);
      chk_val("sw wstrb", beats_q[0].strb, 4'b1111);
      chk_val("sw wdata", beats_q[0].data, 32'hDEAD_BEEF);
    end

    do_req(1'b0, 2'd3, 1'b0, 32'h1000, 32'h0, 0);

    @(negedge clk);
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_size = 2'd1; b_req_addr = 32'h1001;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    chk_val("al fault valid", b_rsp_valid, 1);
    chk_val("al fault flag", b_rsp_fault, 1);
    chk_val("al fault no bus", b_mem_valid, 0);
    chk_val("al fault rdata", b_rsp_rdata, 0);
    @(posedge clk);
    @(negedge clk);
    b_req_valid = 1'b1; b_req_addr = 32'h1002;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    chk_val("al aligned bus", b_mem_valid, 1);
    chk_val("al aligned no rsp", b_rsp_valid, 0);

    rd_lag = 3;
    @(negedge clk);
    beats_q.delete();
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h1000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk_val("rst rd0 beat", beats_q.size(), 1);
    chk_val("rst rd0 busy", req_ready, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_val("rst rd0 mem_valid", mem_valid, 0);
    chk_val("rst rd0 req_ready", req_ready, 1);
    chk_val("rst rd0 rsp_valid", rsp_valid, 0);
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rsp_valid === 1'b1) seen++;
    end
    chk_val("rst stray rsp", seen, 0);
    chk_val("rst stray req_ready", req_ready, 1);
    chk_val("rst stray rdata", rsp_rdata, 0);
    rd_lag = -1;

    for (int n = 0; n < 150; n++) begin
      logic [1:0] sz;
      rand_wait   = (n >= 75);
      chk_latency = (n < 75);
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
             32'h1000 + $urandom_range(0, 59), $urandom, 0);
    end

    for (int w = 0; w < 16; w++)
      chk_val("final mem word", mem_word(32'h1000 + 4*w),
              {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]});

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got 1, expected 0");
    $fatal(1, "timeout");
  end

endmodule
